// File: rtl/bitcell_ctrl.sv
// ============================================================================
//  Module      : bitcell_ctrl
//  Description : Request-driven controller that pulses NAND SR-latch bit cells
//                for writes and captures latch outputs for reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitcell_ctrl #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int PULSE_CYCLES = 2,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [AW-1:0]          req_addr,
    input  logic [WIDTH-1:0]       req_wdata,
    output logic                   rsp_valid,
    output logic [WIDTH-1:0]       rsp_rdata,
    output logic [DEPTH*WIDTH-1:0] cell_set_n,
    output logic [DEPTH*WIDTH-1:0] cell_reset_n,
    input  logic [DEPTH*WIDTH-1:0] cell_q
);

    localparam int               c_CNT_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        RECOVER = 2'd2,
        READ    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [AW-1:0]        r_addr;
    logic [WIDTH-1:0]     r_wdata;
    logic [WIDTH-1:0]     r_rdata;
    logic                 r_ready;
    logic                 r_rsp_valid;
    logic [WIDTH-1:0]     w_rd_word;
    logic                 w_accept;

    // r_ready is only ever high in IDLE, so it alone qualifies acceptance
    assign w_accept = r_ready & req_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = req_write ? PULSE : READ;
            PULSE:   if (r_cnt == c_LAST) w_next = RECOVER;
            RECOVER: w_next = IDLE;
            READ:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Out-of-range addresses match no word and read back as zero
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_addr == AW'(i)) w_rd_word = cell_q[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ready     <= (w_next == IDLE);
            r_rsp_valid <= (r_state == READ);
            r_cnt       <= (r_state == PULSE) ? r_cnt + c_CNT_W'(1) : '0;
            if (r_state == READ) r_rdata <= w_rd_word;
            if (w_accept) r_addr <= req_addr;
            if (w_accept && req_write) r_wdata <= req_wdata;
        end
    end

    // Set and reset of one cell are complements of a single data bit,
    // so both can never be low together.
    generate
        for (genvar w = 0; w < DEPTH; w++) begin : g_word
            logic w_sel;
            assign w_sel = (r_state == PULSE) && (r_addr == AW'(w));
            assign cell_set_n[w*WIDTH +: WIDTH]   = w_sel ? ~r_wdata : {WIDTH{1'b1}};
            assign cell_reset_n[w*WIDTH +: WIDTH] = w_sel ?  r_wdata : {WIDTH{1'b1}};
        end
    endgenerate

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_bitcell_ctrl.sv
// ============================================================================
//  Module      : tb_bitcell_ctrl
//  Description : Bench for bitcell_ctrl with a behavioural SR-latch array.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitcell_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int P     = 2;
    localparam int AW    = 2;
    localparam int N     = DEPTH * WIDTH;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_write = 1'b0;
    logic [AW-1:0]    req_addr = '0;
    logic [WIDTH-1:0] req_wdata = '0;
    logic             req_ready;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic [N-1:0]     cell_set_n;
    logic [N-1:0]     cell_reset_n;
    logic [N-1:0]     cell_q = '0;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last_rd = '0;

    bitcell_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PULSE_CYCLES(P)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .cell_set_n   (cell_set_n),
        .cell_reset_n (cell_reset_n),
        .cell_q       (cell_q)
    );

    always #5 clk = ~clk;

    // NAND SR latch array: set_n low forces 1, reset_n low forces 0
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!cell_set_n[i])        cell_q[i] <= 1'b1;
            else if (!cell_reset_n[i]) cell_q[i] <= 1'b0;
        end
    end

    always @(negedge clk) begin
        checks++;
        if ((~cell_set_n & ~cell_reset_n) !== '0) begin
            errors++;
            $display("FAIL both_low set_n=%h reset_n=%h expected no common zero", cell_set_n, cell_reset_n);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout ready=%b expected 1", nm, req_ready);
        end
    endtask

    task automatic do_write(input int a, input logic [WIDTH-1:0] d);
        logic [N-1:0] es;
        logic [N-1:0] er;
        es = '1;
        er = '1;
        for (int b = 0; b < WIDTH; b++) begin
            if (d[b]) es[a*WIDTH + b] = 1'b0;
            else      er[a*WIDTH + b] = 1'b0;
        end
        wait_ready("write");
        req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(a); req_wdata = d;
        step();
        req_valid = 1'b0; req_write = 1'b0; req_wdata = WIDTH'($urandom);
        for (int k = 1; k <= P; k++) begin
            checks++;
            if (cell_set_n !== es || cell_reset_n !== er || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL write_pulse cyc%0d set_n=%h reset_n=%h ready=%b expected set_n=%h reset_n=%h ready=0",
                         k, cell_set_n, cell_reset_n, req_ready, es, er);
            end
            step();
        end
        checks++;
        if (cell_set_n !== '1 || cell_reset_n !== '1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_recover set_n=%h reset_n=%h ready=%b expected all ones, ready=0",
                     cell_set_n, cell_reset_n, req_ready);
        end
        step();
        checks++;
        if (req_ready !== 1'b1 || cell_set_n !== '1 || cell_reset_n !== '1) begin
            errors++;
            $display("FAIL write_occupancy ready=%b expected 1 at accept+%0d", req_ready, P + 2);
        end
        mem[a] = d;
    endtask

    task automatic do_read(input int a);
        wait_ready("read");
        req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(a);
        step();
        req_valid = 1'b0; req_addr = AW'($urandom);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== last_rd) begin
            errors++;
            $display("FAIL read_busy valid=%b ready=%b rdata=%h expected 0,0,%h", rsp_valid, req_ready, rsp_rdata, last_rd);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== mem[a] || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_data addr%0d valid=%b rdata=%h ready=%b expected 1,%h,1", a, rsp_valid, rsp_rdata, req_ready, mem[a]);
        end
        last_rd = mem[a];
        step();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== last_rd) begin
            errors++;
            $display("FAIL read_pulse_hold valid=%b rdata=%h expected 0,%h", rsp_valid, rsp_rdata, last_rd);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (cell_set_n !== '1 || cell_reset_n !== '1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state set_n=%h reset_n=%h valid=%b rdata=%h ready=%b expected ones,ones,0,0,0",
                     cell_set_n, cell_reset_n, rsp_valid, rsp_rdata, req_ready);
        end
        reset = 1'b0;
        step();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release ready=%b valid=%b expected 1,0", req_ready, rsp_valid);
        end
        last_rd = '0;
    endtask

    task automatic test_write_read();
        do_write(2, 8'hA5);
        do_read(2);
    endtask

    task automatic test_overwrite();
        do_write(1, 8'h3C);
        do_write(0, 8'hFF);
        do_write(0, 8'h00);
        do_read(0);
        do_read(1);
    endtask

    task automatic test_back_to_back();
        do_write(3, WIDTH'($urandom));
        do_write(1, WIDTH'($urandom));
        wait_ready("b2b");
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd3;
        step();
        req_addr = 2'd1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy ready=%b valid=%b expected 0,0", req_ready, rsp_valid);
        end
        step();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== mem[3]) begin
            errors++;
            $display("FAIL b2b_first ready=%b valid=%b rdata=%h expected 1,1,%h", req_ready, rsp_valid, rsp_rdata, mem[3]);
        end
        step();
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== mem[3]) begin
            errors++;
            $display("FAIL b2b_hold ready=%b valid=%b rdata=%h expected 0,0,%h", req_ready, rsp_valid, rsp_rdata, mem[3]);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== mem[1] || cell_set_n !== '1 || cell_reset_n !== '1) begin
            errors++;
            $display("FAIL b2b_second valid=%b rdata=%h expected 1,%h", rsp_valid, rsp_rdata, mem[1]);
        end
        last_rd = mem[1];
        step();
    endtask

    task automatic test_reset_mid_pulse();
        wait_ready("midrst");
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd3; req_wdata = ~mem[3];
        step();
        req_valid = 1'b0; req_write = 1'b0;
        reset = 1'b1;
        step();
        checks++;
        if (cell_set_n !== '1 || cell_reset_n !== '1 || rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== '0) begin
            errors++;
            $display("FAIL midrst_lines set_n=%h reset_n=%h valid=%b ready=%b rdata=%h expected ones,ones,0,0,0",
                     cell_set_n, cell_reset_n, rsp_valid, req_ready, rsp_rdata);
        end
        reset = 1'b0;
        last_rd = '0;
        step();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release ready=%b valid=%b expected 1,0", req_ready, rsp_valid);
        end
        // The abandoned write left word 3 undefined; restore the reference value
        do_write(3, mem[3]);
        do_read(3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int a;
            a = int'($urandom_range(DEPTH - 1, 0));
            if ($urandom_range(1, 0) == 1) do_write(a, WIDTH'($urandom));
            else                           do_read(a);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_write_read();
        test_overwrite();
        test_back_to_back();
        test_reset_mid_pulse();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
